four_bit_adder: RTL and testbench



---
 rtl/four_bit_adder.sv | 72 +++++++
 tb/tb_four_bit_adder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder, 5-bit result with carry-out.
// Define FOUR_BIT_ADDER_OVF_EN to add a registered signed-overflow output ovf.
module four_bit_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] s,
`ifdef FOUR_BIT_ADDER_OVF_EN
    output logic       ovf,
`endif
    output logic       out_valid
);

    logic [4:0] c;
    logic [3:0] sum;
    logic [4:0] s_d, s_q;
    logic       vld_d, vld_q;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    // Operands are ignored while idle, so X on a/b cannot reach s.
    always_comb begin
        s_d   = s_q;
        vld_d = 1'b0;
        if (in_valid) begin
            s_d   = {c[4], sum};
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 5'd0;
            vld_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            vld_q <= vld_d;
        end
    end

    assign s         = s_q;
    assign out_valid = vld_q;

`ifdef FOUR_BIT_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = c[4] ^ c[3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed and exhaustive checks for four_bit_adder.
// Overflow checks are compiled in when FOUR_BIT_ADDER_OVF_EN is defined.
module tb_four_bit_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] s;
    logic       out_valid;
`ifdef FOUR_BIT_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    four_bit_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .s         (s),
`ifdef FOUR_BIT_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after an edge; outputs are sampled there too.
    task automatic drive(input logic [3:0] av, input logic [3:0] bv,
                         input logic v);
        a        = av;
        b        = bv;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [3:0] av,
                       input logic [3:0] bv, input logic [4:0] exp);
        drive(av, bv, 1'b1);
        chk(tag, s, exp);
        chk({tag, "_vld"}, 5'(out_valid), 5'd1);
    endtask

    initial begin
        logic [7:0] ab;
        logic [4:0] exp;

        rst_n    = 1'b0;
        a        = 4'hF;
        b        = 4'hF;
        in_valid = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_s", s, 5'd0);
            chk("rst_vld", 5'(out_valid), 5'd0);
`ifdef FOUR_BIT_ADDER_OVF_EN
            chk("rst_ovf", 5'(ovf), 5'd0);
`endif
        end

        rst_n = 1'b1;
        vec("first_cap", 4'hF, 4'hF, 5'd30);

        rst_n = 1'b0;
        #1;
        chk("async_s", s, 5'd0);
        chk("async_vld", 5'(out_valid), 5'd0);
        #1;
        rst_n = 1'b1;

        vec("v_0_0", 4'd0, 4'd0, 5'd0);
        vec("v_0_1", 4'd0, 4'd1, 5'd1);
        vec("v_0_15", 4'd0, 4'd15, 5'd15);
        vec("v_15_15", 4'd15, 4'd15, 5'd30);
        vec("v_1_15", 4'd1, 4'd15, 5'd16);

        for (int i = 0; i < 256; i++) begin
            ab  = 8'(i);
            exp = {1'b0, ab[7:4]} + {1'b0, ab[3:0]};
            drive(ab[7:4], ab[3:0], 1'b1);
            chk("exh", s, exp);
        end

        vec("hold_src", 4'd5, 4'd6, 5'd11);
        drive(4'bxxxx, 4'bxxxx, 1'b0);
        chk("hold_x_s", s, 5'd11);
        chk("hold_x_vld", 5'(out_valid), 5'd0);
        for (int k = 0; k < 2; k++) begin
            drive(4'($urandom), 4'($urandom), 1'b0);
            chk("hold_s", s, 5'd11);
            chk("hold_vld", 5'(out_valid), 5'd0);
        end

        vec("mid_9_9", 4'd9, 4'd9, 5'd18);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s", s, 5'd0);
        chk("mid_rst_vld", 5'(out_valid), 5'd0);
        #4;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_s", s, 5'd0);
        chk("post_rst_vld", 5'(out_valid), 5'd0);
        vec("post_2_3", 4'd2, 4'd3, 5'd5);

`ifdef FOUR_BIT_ADDER_OVF_EN
        drive(4'd7, 4'd1, 1'b1);
        chk("ovf_7_1", 5'(ovf), 5'd1);
        drive(4'd8, 4'd8, 1'b1);
        chk("ovf_8_8", 5'(ovf), 5'd1);
        drive(4'd15, 4'd15, 1'b1);
        chk("ovf_15_15", 5'(ovf), 5'd0);
        drive(4'd7, 4'd1, 1'b1);
        drive(4'd0, 4'd0, 1'b0);
        chk("ovf_hold", 5'(ovf), 5'd1);
        drive(4'd3, 4'd4, 1'b1);
        chk("ovf_3_4", 5'(ovf), 5'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
